// File: rtl/fp32_arith_unit.sv
// Registered IEEE-754 single-precision add/sub/mul/div, one op per cycle, latency 1.
// Subnormals are flushed to zero on input and output; rounding is nearest-even.
module fp32_arith_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_invalid,
  output logic        flag_div_zero
);

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpDiv = 2'b11} opE;

  logic [7:0]  expA, expB;
  logic        aZero, bZero, aInf, bInf, aNan, bNan;
  logic [23:0] manA, manB;
  logic [30:0] magA, magB;

  assign expA  = a[30:23];
  assign expB  = b[30:23];
  assign aZero = (expA == 8'd0);
  assign bZero = (expB == 8'd0);
  assign aInf  = (expA == 8'hFF) && (a[22:0] == 23'd0);
  assign bInf  = (expB == 8'hFF) && (b[22:0] == 23'd0);
  assign aNan  = (expA == 8'hFF) && (a[22:0] != 23'd0);
  assign bNan  = (expB == 8'hFF) && (b[22:0] != 23'd0);
  assign manA  = aZero ? 24'd0 : {1'b1, a[22:0]};
  assign manB  = bZero ? 24'd0 : {1'b1, b[22:0]};
  assign magA  = aZero ? 31'd0 : a[30:0];
  assign magB  = bZero ? 31'd0 : b[30:0];

  logic               signBEff, swapOps, signBig, signSmall;
  logic [7:0]         expBig, shiftAmt;
  logic [23:0]        manBig, manSmall;
  logic [26:0]        shiftedSmall, alignedSmall, addNorm;
  logic [27:0]        sumRaw;
  logic [4:0]         lzCount;
  logic signed [10:0] addExp;
  logic               addIsZero;

  // Align the smaller magnitude with sticky collection, then add/sub and normalise.
  always_comb begin
    signBEff  = b[31] ^ op[0];
    swapOps   = magB > magA;
    signBig   = swapOps ? signBEff : a[31];
    signSmall = swapOps ? a[31] : signBEff;
    expBig    = swapOps ? expB : expA;
    manBig    = swapOps ? manB : manA;
    manSmall  = swapOps ? manA : manB;
    shiftAmt  = swapOps ? (expB - expA) : (expA - expB);
    shiftedSmall = {manSmall, 3'b000} >> shiftAmt;
    if (shiftAmt >= 8'd27)
      alignedSmall = {26'd0, |manSmall};
    else
      alignedSmall = shiftedSmall | {26'd0, (shiftedSmall << shiftAmt) != {manSmall, 3'b000}};
    if (signBig ^ signSmall)
      sumRaw = {1'b0, manBig, 3'b000} - {1'b0, alignedSmall};
    else
      sumRaw = {1'b0, manBig, 3'b000} + {1'b0, alignedSmall};
    addIsZero = (sumRaw == 28'd0);
    lzCount = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sumRaw[i]) lzCount = 5'(26 - i);
    addExp = $signed({3'b000, expBig});
    if (sumRaw[27]) begin
      addNorm = {sumRaw[27:2], sumRaw[1] | sumRaw[0]};
      addExp  = addExp + 11'sd1;
    end else begin
      addNorm = sumRaw[26:0] << lzCount;
      addExp  = addExp - $signed({6'd0, lzCount});
    end
  end

  logic [47:0] prod;
  logic [26:0] quo;
  logic [25:0] rem;

  // Restoring divider: quotient bit 26 has weight 1.0, so 27 bits cover 24 + guard/round.
  always_comb begin
    prod = manA * manB;
    quo  = 27'd0;
    rem  = {2'b00, manA};
    for (int i = 26; i >= 0; i--) begin
      if (rem >= {2'b00, manB}) begin
        quo[i] = 1'b1;
        rem    = rem - {2'b00, manB};
      end
      rem = rem << 1;
    end
  end

  logic               rSign, rG, rR, rS, roundUp;
  logic signed [10:0] rExp, expRnd;
  logic [23:0]        rMant, mantFinal;
  logic [24:0]        mantRnd;

  always_comb begin
    rSign = a[31] ^ b[31];
    rExp  = 11'sd0;
    rMant = 24'd0;
    rG    = 1'b0;
    rR    = 1'b0;
    rS    = 1'b0;
    case (opE'(op))
      OpAdd, OpSub: begin
        rSign = signBig;
        rExp  = addExp;
        {rMant, rG, rR, rS} = addNorm;
      end
      OpMul: begin
        rExp = $signed({3'b000, expA}) + $signed({3'b000, expB}) - 11'sd127
             + $signed({10'd0, prod[47]});
        if (prod[47]) {rMant, rG, rR, rS} = {prod[47:22], |prod[21:0]};
        else          {rMant, rG, rR, rS} = {prod[46:21], |prod[20:0]};
      end
      OpDiv: begin
        rExp = $signed({3'b000, expA}) - $signed({3'b000, expB}) + 11'sd127
             - $signed({10'd0, ~quo[26]});
        if (quo[26]) {rMant, rG, rR, rS} = {quo[26:1], quo[0] | (rem != 26'd0)};
        else         {rMant, rG, rR, rS} = {quo[25:0], rem != 26'd0};
      end
      default: ;
    endcase
    roundUp   = rG & (rR | rS | rMant[0]);
    mantRnd   = {1'b0, rMant} + {24'd0, roundUp};
    expRnd    = rExp + $signed({10'd0, mantRnd[24]});
    mantFinal = mantRnd[24] ? mantRnd[24:1] : mantRnd[23:0];
  end

  logic        validQ, validD;
  logic [31:0] resultQ, resultD;
  logic        ovfQ, ovfD, unfQ, unfD, invQ, invD, dzQ, dzD;
  logic [31:0] roundedRes;
  logic        roundedOvf, roundedUnf;

  always_comb begin
    roundedOvf = 1'b0;
    roundedUnf = 1'b0;
    if (expRnd >= 11'sd255) begin
      roundedRes = {rSign, 8'hFF, 23'd0};
      roundedOvf = 1'b1;
    end else if (expRnd <= 11'sd0) begin
      roundedRes = {rSign, 31'd0};
      roundedUnf = 1'b1;
    end else begin
      roundedRes = {rSign, expRnd[7:0], mantFinal[22:0]};
    end
  end

  // Special operands take priority over the arithmetic path; flags describe only this op.
  always_comb begin
    validD  = in_valid;
    resultD = roundedRes;
    ovfD    = roundedOvf;
    unfD    = roundedUnf;
    invD    = 1'b0;
    dzD     = 1'b0;
    if (aNan || bNan) begin
      resultD = QNaN; ovfD = 1'b0; unfD = 1'b0; invD = 1'b1;
    end else begin
      case (opE'(op))
        OpAdd, OpSub: begin
          if (aInf || bInf || addIsZero) begin
            ovfD = 1'b0; unfD = 1'b0;
            if (aInf && bInf && (a[31] != signBEff)) begin
              resultD = QNaN; invD = 1'b1;
            end else if (aInf)   resultD = {a[31], 8'hFF, 23'd0};
            else if (bInf)       resultD = {signBEff, 8'hFF, 23'd0};
            else                 resultD = {a[31] & signBEff, 31'd0};
          end
        end
        OpMul: begin
          if (aInf || bInf || aZero || bZero) begin
            ovfD = 1'b0; unfD = 1'b0;
            if ((aInf && bZero) || (aZero && bInf)) begin
              resultD = QNaN; invD = 1'b1;
            end else if (aInf || bInf) resultD = {a[31] ^ b[31], 8'hFF, 23'd0};
            else                       resultD = {a[31] ^ b[31], 31'd0};
          end
        end
        OpDiv: begin
          if (aInf || bInf || aZero || bZero) begin
            ovfD = 1'b0; unfD = 1'b0;
            if ((aZero && bZero) || (aInf && bInf)) begin
              resultD = QNaN; invD = 1'b1;
            end else if (aInf) resultD = {a[31] ^ b[31], 8'hFF, 23'd0};
            else if (bInf)     resultD = {a[31] ^ b[31], 31'd0};
            else if (bZero) begin
              resultD = {a[31] ^ b[31], 8'hFF, 23'd0}; dzD = 1'b1;
            end else           resultD = {a[31] ^ b[31], 31'd0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ  <= 1'b0;
      resultQ <= 32'd0;
      ovfQ    <= 1'b0;
      unfQ    <= 1'b0;
      invQ    <= 1'b0;
      dzQ     <= 1'b0;
    end else begin
      validQ <= validD;
      if (in_valid) begin
        resultQ <= resultD;
        ovfQ    <= ovfD;
        unfQ    <= unfD;
        invQ    <= invD;
        dzQ     <= dzD;
      end
    end
  end

  assign out_valid      = validQ;
  assign result         = resultQ;
  assign flag_overflow  = ovfQ;
  assign flag_underflow = unfQ;
  assign flag_invalid   = invQ;
  assign flag_div_zero  = dzQ;

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Directed-vector bench for fp32_arith_unit; expected values are hand-computed fp32 words.
// Observed word packs {out_valid, overflow, underflow, invalid, div_zero, result}.
module tb_fp32_arith_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic        flag_overflow, flag_underflow, flag_invalid, flag_div_zero;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;
  localparam logic [3:0] NOF = 4'b0000, OVF = 4'b1000, UNF = 4'b0100, INV = 4'b0010, DZ = 4'b0001;

  fp32_arith_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .op             (op),
    .a              (a),
    .b              (b),
    .out_valid      (out_valid),
    .result         (result),
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow),
    .flag_invalid   (flag_invalid),
    .flag_div_zero  (flag_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] observed();
    return {out_valid, flag_overflow, flag_underflow, flag_invalid, flag_div_zero, result};
  endfunction

  task automatic checkOutput(input string tag, input logic [36:0] obs, input logic [36:0] expv);
    checkCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got v/flags=%b result=%h, expected v/flags=%b result=%h",
               tag, obs[36:32], obs[31:0], expv[36:32], expv[31:0]);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] expRes, input logic [3:0] expFlags);
    applyStimulus(1'b1, o, x, y);
    @(posedge clk);
    #1;
    checkOutput(tag, observed(), {1'b1, expFlags, expRes});
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, ADD, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", observed(), 37'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: a new operation every cycle
    runOp("add_1p2",        ADD, 32'h3F800000, 32'h40000000, 32'h40400000, NOF);
    runOp("sub_1m0p5",      SUB, 32'h3F800000, 32'h3F000000, 32'h3F000000, NOF);
    runOp("mul_2x3",        MUL, 32'h40000000, 32'h40400000, 32'h40C00000, NOF);
    runOp("div_24d2",       DIV, 32'h41C00000, 32'h40000000, 32'h41400000, NOF);
    runOp("div_by_zero",    DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, DZ);
    runOp("div_0d0",        DIV, 32'h00000000, 32'h00000000, 32'h7FC00000, INV);
    runOp("mul_overflow",   MUL, 32'h7F000000, 32'h40000000, 32'h7F800000, OVF);
    runOp("mul_underflow",  MUL, 32'h00800000, 32'h3F000000, 32'h00000000, UNF);
    runOp("sub_cancel",     SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, NOF);
    runOp("add_inf_ninf",   ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, INV);
    runOp("add_tie_even",   ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, NOF);
    runOp("add_tie_up",     ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, NOF);
    runOp("add_far_tie",    ADD, 32'h4B800000, 32'h3F800000, 32'h4B800000, NOF);
    runOp("div_1d3",        DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NOF);
    runOp("sub_negative",   SUB, 32'h3F800000, 32'h40000000, 32'hBF800000, NOF);
    runOp("mul_1p5sq",      MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, NOF);
    runOp("mul_0xinf",      MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, INV);
    runOp("div_by_inf",     DIV, 32'hC0000000, 32'h7F800000, 32'h80000000, NOF);
    runOp("mul_neg_inf",    MUL, 32'hC0000000, 32'h7F800000, 32'hFF800000, NOF);
    runOp("div_zero_num",   DIV, 32'h00000000, 32'h40000000, 32'h00000000, NOF);
    runOp("add_subnormal",  ADD, 32'h00400000, 32'h3F800000, 32'h3F800000, NOF);
    runOp("add_nan",        ADD, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, INV);
    runOp("add_negzeros",   ADD, 32'h80000000, 32'h80000000, 32'h80000000, NOF);
    runOp("add_overflow",   ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, OVF);

    // Idle cycle: out_valid drops, result and flags hold the last op
    applyStimulus(1'b0, MUL, 32'h40000000, 32'h40000000);
    @(posedge clk);
    #1;
    checkOutput("idle_hold", observed(), {1'b0, OVF, 32'h7F800000});

    runOp("flags_clear",    ADD, 32'h3F800000, 32'h40000000, 32'h40400000, NOF);

    // Reset asserted mid-stream clears outputs without waiting for an edge
    applyStimulus(1'b1, MUL, 32'h40000000, 32'h40400000);
    @(posedge clk);
    #1;
    checkOutput("pre_reset", observed(), {1'b1, NOF, 32'h40C00000});
    applyStimulus(1'b1, DIV, 32'h3F800000, 32'h00000000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", observed(), 37'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", observed(), 37'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after_reset",    SUB, 32'h40400000, 32'h3F800000, 32'h40000000, NOF);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
